// File: rtl/scr1_trace_pkg.sv
// Shared types for the retirement trace buffer: event flags, stored entry layout,
// capture mode and RING trigger states.
package scr1_trace_pkg;

    localparam int SCR1_TRACE_XLEN  = 32;
    localparam int SCR1_TRACE_DLY_W = 16;

    typedef struct packed {
        logic trap;
        logic mprf;
        logic retire;
    } type_scr1_trace_ev_s;

    typedef struct packed {
        type_scr1_trace_ev_s           ev;
        logic [SCR1_TRACE_XLEN-1:0]    pc;
        logic [4:0]                    rd_addr;
        logic [SCR1_TRACE_XLEN-1:0]    rd_data;
        logic [SCR1_TRACE_DLY_W-1:0]   dly;
    } type_scr1_trace_entry_s;

    typedef enum logic {
        STREAM = 1'b0,
        RING   = 1'b1
    } type_scr1_trace_mode_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        FROZEN = 2'd2
    } type_scr1_trace_fsm_e;

endpackage

// File: rtl/scr1_trace_ram.sv
// Trace entry storage: one synchronous write port, one asynchronous read port.
// Contents are not reset; validity is tracked by the pointers in the top.
module scr1_trace_ram
    import scr1_trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   we,
    input  logic [PTR_W-1:0]       waddr,
    input  type_scr1_trace_entry_s wdata,
    input  logic [PTR_W-1:0]       raddr,
    output type_scr1_trace_entry_s rdata
);

    type_scr1_trace_entry_s mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/scr1_trace_buf.sv
// Retirement trace buffer: captures retire/MPRF/trap events into a circular store
// and drains them on a valid/ready port, in lossy STREAM or triggered RING mode.
module scr1_trace_buf
    import scr1_trace_pkg::*;
#(
    parameter int XLEN  = SCR1_TRACE_XLEN,
    parameter int DEPTH = 16,
    parameter int PTR_W = $clog2(DEPTH),
    parameter int DLY_W = SCR1_TRACE_DLY_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_en,
    input  logic                   cfg_mode,
    input  logic [PTR_W:0]         cfg_post,
    input  logic                   cfg_clr,
    input  logic                   trig,
    input  logic                   retire_vld,
    input  logic [XLEN-1:0]        retire_pc,
    input  logic                   mprf_wr_en,
    input  logic [4:0]             mprf_wr_addr,
    input  logic [XLEN-1:0]        mprf_wr_data,
    input  logic                   trap_vld,
    input  logic [XLEN-1:0]        trap_cause,
    output logic                   out_vld,
    input  logic                   out_rdy,
    output type_scr1_trace_entry_s out_entry,
    output logic [PTR_W:0]         cnt,
    output logic                   overflow,
    output logic [15:0]            drop_cnt,
    output logic                   frozen
);

    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   ONE_CNT  = (PTR_W+1)'(1);
    localparam logic [DLY_W-1:0] DLY_MAX  = {DLY_W{1'b1}};

    type_scr1_trace_mode_e  mode;
    type_scr1_trace_fsm_e   fsm;
    type_scr1_trace_entry_s wr_entry;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   post_rem;
    logic [DLY_W-1:0] dly_cnt;
    logic             capture;
    logic             full;
    logic             pop;
    logic             push;
    logic             drop;
    logic             rd_adv;

    assign mode    = type_scr1_trace_mode_e'(cfg_mode);
    assign capture = cfg_en & ~frozen & (retire_vld | mprf_wr_en | trap_vld);
    assign full    = (cnt == FULL_CNT);
    assign out_vld = (mode == RING) ? (frozen & (cnt != '0)) : (cnt != '0);
    assign pop     = out_vld & out_rdy;

    // STREAM drops only when full and nothing leaves this cycle; RING always
    // writes and pushes the oldest entry out when full.
    assign push    = ~cfg_clr & capture & ((mode == RING) | ~full | pop);
    assign drop    = ~cfg_clr & capture & (mode == STREAM) & full & ~pop;
    assign rd_adv  = pop | (push & (mode == RING) & full);

    always_comb begin
        wr_entry.ev.trap   = trap_vld;
        wr_entry.ev.mprf   = mprf_wr_en;
        wr_entry.ev.retire = retire_vld;
        wr_entry.pc        = trap_vld ? trap_cause : retire_pc;
        wr_entry.rd_addr   = mprf_wr_en ? mprf_wr_addr : 5'd0;
        wr_entry.rd_data   = mprf_wr_en ? mprf_wr_data : '0;
        wr_entry.dly       = dly_cnt;
    end

    scr1_trace_ram #(.DEPTH(DEPTH), .PTR_W(PTR_W)) i_ram (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (wr_entry),
        .raddr (rd_ptr),
        .rdata (out_entry)
    );

    always_ff @(posedge clk) begin
        if (rst || cfg_clr) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
            dly_cnt  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_adv) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !rd_adv) begin
                cnt <= cnt + ONE_CNT;
            end else if (rd_adv && !push) begin
                cnt <= cnt - ONE_CNT;
            end
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != 16'hFFFF) begin
                    drop_cnt <= drop_cnt + 16'd1;
                end
            end
            // Dropped events still count as captures for the delay field.
            if (capture) begin
                dly_cnt <= DLY_W'(1);
            end else if (dly_cnt != DLY_MAX) begin
                dly_cnt <= dly_cnt + DLY_W'(1);
            end
        end
    end

    // RING trigger: the trigger-cycle capture is not counted because the
    // decrement only happens once ARMED.
    always_ff @(posedge clk) begin
        if (rst || cfg_clr) begin
            fsm      <= IDLE;
            post_rem <= '0;
            frozen   <= 1'b0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (trig && cfg_en && (mode == RING)) begin
                        fsm      <= ARMED;
                        post_rem <= cfg_post;
                    end
                end
                ARMED: begin
                    if (post_rem == '0) begin
                        fsm    <= FROZEN;
                        frozen <= 1'b1;
                    end else if (capture) begin
                        post_rem <= post_rem - ONE_CNT;
                        if (post_rem == ONE_CNT) begin
                            fsm    <= FROZEN;
                            frozen <= 1'b1;
                        end
                    end
                end
                FROZEN: begin
                    fsm <= FROZEN;
                end
                default: begin
                    fsm <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/scr1_trace_buf.md
Name: scr1_trace_buf

Overview:
Synthesizable on-chip retirement trace buffer, the hardware successor to the simulation-only tracelog. It captures PC-retire, MPRF-write and trap events into a parametrised circular buffer and exposes them on a valid/ready drain port. It runs in one of two modes: STREAM (lossy FIFO with drop accounting) or RING (continuous overwrite, frozen a programmable number of events after a trigger). It sits beside the EXU/CSR and is read by the debug unit.

Parameters:
XLEN, 32, data/PC width
DEPTH, 16, entries; power of two, >= 2
PTR_W, $clog2(DEPTH), pointer width
DLY_W, 16, inter-event delay field width

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
cfg_en  in  1  capture enable
cfg_mode  in  1  0=STREAM, 1=RING
cfg_post  in  PTR_W+1  RING: captures after trigger before freeze
cfg_clr  in  1  pulse: flush buffer and status
trig  in  1  RING trigger pulse
retire_vld  in  1  instruction retired
retire_pc  in  XLEN  PC of retired instruction
mprf_wr_en  in  1  register write
mprf_wr_addr  in  5  register index
mprf_wr_data  in  XLEN  write data
trap_vld  in  1  trap taken
trap_cause  in  XLEN  mcause value
out_vld  out  1  entry available
out_rdy  in  1  consumer accepts
out_entry  out  type_scr1_trace_entry_s  head entry
cnt  out  PTR_W+1  occupancy
overflow  out  1  sticky: STREAM drop occurred
drop_cnt  out  16  saturating dropped-event count
frozen  out  1  RING: capture stopped after trigger

Behaviour:
- Reset: all outputs 0, pointers 0, delay counter 0, trigger disarmed.
- Capture event: cfg_en & ~frozen & (retire_vld | mprf_wr_en | trap_vld). One entry per cycle.
- Entry fields:
  - ev flags {trap, mprf, retire};
  - pc = retire_pc, or trap_cause when trap_vld;
  - rd_addr, rd_data (zeroed when ~mprf_wr_en; address 0 is captured as-is);
  - dly = cycles since previous capture (or since reset/clr), saturating at 2^DLY_W-1.
- Delay counter: reset to 1 on the cycle after each capture.
- Latency: an entry written at edge N is visible on out_* after edge N; out_entry comes straight from the storage head (no extra register).
- Drain: pop on out_vld & out_rdy. out_entry holds stable while out_vld & ~out_rdy.
- STREAM mode:
  - out_vld = cnt != 0.
  - When full with no pop that cycle, the event is dropped: overflow <= 1, drop_cnt++ (saturating at 0xFFFF).
  - When full with a pop in the same cycle, the push is accepted and cnt is unchanged.
- RING mode:
  - out_vld = frozen & (cnt != 0).
  - When full, a capture overwrites the oldest entry (rd_ptr advances, cnt stays DEPTH).
  - Pops are ignored until frozen.
- RING trigger FSM: IDLE -> ARMED on trig (only when cfg_en & ~frozen), loading post_rem = cfg_post.
  - The capture in the trigger cycle is stored and not counted.
  - In ARMED, each capture decrements post_rem.
  - Freeze occurs at the first capture edge at which post_rem reaches 0, or on the cycle after trig if cfg_post = 0: FROZEN, frozen <= 1.
  - trig in ARMED or FROZEN is ignored.
  - FROZEN persists through draining.
- cfg_clr, highest priority below rst:
  - empties the buffer (cnt, pointers);
  - clears overflow, drop_cnt and frozen; FSM to IDLE;
  - resets the delay counter;
  - any same-cycle event is discarded.
- cfg_mode changes are legal only while empty or after cfg_clr; otherwise the result is unspecified.
- cfg_en low: no capture, no drops counted, draining continues.

Decomposition:
- Package scr1_trace_pkg holds:
  - type_scr1_trace_ev_s (3 flag bits);
  - type_scr1_trace_entry_s {ev, pc, rd_addr, rd_data, dly};
  - type_scr1_trace_mode_e (STREAM, RING);
  - type_scr1_trace_fsm_e (IDLE, ARMED, FROZEN).
- Submodule scr1_trace_ram: DEPTH x entry, 1 write / 1 asynchronous read register array, no reset on data.

Test Plan:
1. STREAM, DEPTH=16, out_rdy=0; 20 retire events, one per cycle, PC 0x200..0x24C -> cnt=16, overflow=1, drop_cnt=4. Raise out_rdy -> 16 pops, PCs 0x200..0x23C in order, dly=1 each.
2. STREAM full, retire and out_rdy together for 5 cycles -> drop_cnt unchanged, cnt stays 16, pop order preserved.
3. RING, cfg_post=3; 40 retires, PC 0x1000+4i, trig at i=30 -> frozen after i=33; drained entries are i=18..33; further retires ignored.
4. RING, cfg_post=0, trig with capture at PC 0x80 -> frozen next cycle; last drained entry pc=0x80; second trig ignored.
5. Events separated by 5 idle cycles, then by 70000 idle cycles -> dly=6, then dly=0xFFFF.
6. mprf_wr_en (x10, 0xDEADBEEF) and trap_vld (cause 0x8000000B) in the same cycle with buffer partly full; then cfg_clr while out_vld -> entry ev=3'b110, pc=0x8000000B, rd=10, data=0xDEADBEEF; after clr cnt=0, out_vld=0, overflow=0.
